// File: rtl/fmap_streamer_if.sv
// Purpose: bundles the fill-side, control and replay-side signals of fmap_streamer.
// Latency: none, wiring only.
// Backpressure: none; the stream is vld-only and the consumer must accept every pixel.
interface fmap_streamer_if #(
    parameter int N       = 16,
    parameter int CHANNEL = 3
);
    logic                   wr_vld;
    logic [CHANNEL*N-1:0]   wr_din;
    logic                   wr_end;
    logic                   start;
    logic                   ready;
    logic                   busy;
    logic                   dout_vld;
    logic [CHANNEL*N-1:0]   dout;
    logic                   dout_end;
    logic                   err;

    // Producer/controller side: feeds pixels and requests replays.
    modport master (
        output wr_vld, wr_din, wr_end, start,
        input  ready, busy, dout_vld, dout, dout_end, err
    );

    // Streamer side.
    modport slave (
        input  wr_vld, wr_din, wr_end, start,
        output ready, busy, dout_vld, dout, dout_end, err
    );
endinterface

// File: rtl/fmap_streamer.sv
// Purpose: stores one SIZE x SIZE multi-channel feature map and replays it once in raster order.
// Latency: start sampled at cycle t gives the first pixel at t+2, then one pixel every GAP+1 cycles.
// Backpressure: none; writes outside IDLE/FILL are dropped and flagged on the sticky err (STREAM_GAP_EN enables GAP spacing).
module fmap_streamer #(
    parameter int N       = 16,
    parameter int CHANNEL = 3,
    parameter int SIZE    = 6,
    parameter int GAP     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    fmap_streamer_if.slave bus
);
    localparam int W     = CHANNEL * N;
    localparam int DEPTH = SIZE * SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, FULL, STREAM} state_t;

    state_t         state;
    logic [AW-1:0]  wa;
    logic [AW-1:0]  ra;
    logic           ready_q;
    logic           busy_q;
    logic           dout_vld_q;
    logic [W-1:0]   dout_q;
    logic           dout_end_q;
    logic           err_q;
    // Last pixel has been emitted; one more cycle of busy before returning to IDLE.
    logic           tail;
    logic           gap_idle;
    logic           emit;
    logic           mem_we;

    logic [W-1:0]   mem [DEPTH];

`ifdef STREAM_GAP_EN
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    logic [GW-1:0]  gap_cnt;
    assign gap_idle = (gap_cnt == '0);
`else
    assign gap_idle = 1'b1;
    logic unused_gap;
    assign unused_gap = (GAP != 0);
`endif

    // Only IDLE and FILL accept pixels; wa is 0 in IDLE so it doubles as the IDLE write address.
    assign mem_we = rst_n && bus.wr_vld && ((state == IDLE) || (state == FILL));
    assign emit   = (state == STREAM) && !tail && gap_idle;

    // Frame storage; contents are never reset, ready tracks validity.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wa] <= bus.wr_din;
        end
    end

    // Fill/replay controller with registered outputs; the registered mem read is the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wa         <= '0;
            ra         <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            dout_q     <= '0;
            dout_end_q <= 1'b0;
            err_q      <= 1'b0;
            tail       <= 1'b0;
`ifdef STREAM_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            dout_vld_q <= 1'b0;
            dout_end_q <= 1'b0;
            case (state)
                IDLE: begin
                    // start without a stored frame is silently ignored.
                    if (bus.wr_vld) begin
                        wa    <= AW'(1);
                        state <= FILL;
                        if (bus.wr_end) err_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.wr_vld) begin
                        if (wa == LAST) begin
                            wa      <= '0;
                            state   <= FULL;
                            ready_q <= 1'b1;
                            if (!bus.wr_end) err_q <= 1'b1;
                        end else begin
                            wa <= wa + 1'b1;
                            if (bus.wr_end) err_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (bus.wr_vld) err_q <= 1'b1;
                    if (bus.start) begin
                        state   <= STREAM;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        ra      <= '0;
                        tail    <= 1'b0;
                    end
                end
                STREAM: begin
                    if (bus.wr_vld) err_q <= 1'b1;
                    if (tail) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        tail   <= 1'b0;
                    end else if (emit) begin
                        dout_q     <= mem[ra];
                        dout_vld_q <= 1'b1;
                        if (ra == LAST) begin
                            dout_end_q <= 1'b1;
                            tail       <= 1'b1;
                            ra         <= '0;
                        end else begin
                            ra <= ra + 1'b1;
`ifdef STREAM_GAP_EN
                            gap_cnt <= GW'(GAP);
`endif
                        end
                    end
`ifdef STREAM_GAP_EN
                    if (!tail && !gap_idle) gap_cnt <= gap_cnt - 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.dout     = dout_q;
    assign bus.dout_end = dout_end_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_fmap_streamer.sv
// Purpose: self-checking bench for fmap_streamer; written pixels feed a scoreboard popped on replay.
// Latency: expects the first pixel two cycles after start, then one every GAP+1 cycles.
// Backpressure: none; every bounded wait that expires counts as a failed check.
module tb_fmap_streamer;
    localparam int N       = 16;
    localparam int CHANNEL = 3;
    localparam int SIZE    = 6;
`ifdef STREAM_GAP_EN
    localparam int GAP     = 2;
`else
    localparam int GAP     = 0;
`endif
    localparam int W       = CHANNEL * N;
    localparam int DEPTH   = SIZE * SIZE;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    int   ch_step;
    logic [W-1:0] sb_q[$];

    fmap_streamer_if #(.N(N), .CHANNEL(CHANNEL)) bus ();

    fmap_streamer #(.N(N), .CHANNEL(CHANNEL), .SIZE(SIZE), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency and spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk_word(input int v);
        logic [W-1:0] w;
        for (int c = 0; c < CHANNEL; c++) w[c*N +: N] = N'(v + c * ch_step);
        return w;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.wr_vld = 1'b0; bus.wr_end = 1'b0; bus.start = 1'b0; bus.wr_din = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_frame(input int base, input int k0, input int end_idx,
                               input bit gappy, input bit start_on_last);
        for (int k = k0; k < DEPTH; k++) begin
            if (gappy) begin
                int g;
                g = $urandom_range(0, 3);
                repeat (g) begin
                    @(posedge clk); #1;
                    bus.wr_vld = 1'b0; bus.wr_end = 1'b0;
                end
            end
            @(posedge clk); #1;
            bus.wr_vld = 1'b1;
            bus.wr_din = mk_word(base + k);
            bus.wr_end = (k == end_idx);
            bus.start  = start_on_last && (k == DEPTH - 1);
            sb_q.push_back(mk_word(base + k));
            if (k == DEPTH - 1) begin
                @(negedge clk);
                checks++;
                if (bus.ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_before_last_write got=%b required=0", bus.ready);
                end
            end
        end
        @(posedge clk); #1;
        bus.wr_vld = 1'b0; bus.wr_end = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_fill got=%b required=1", bus.ready);
        end
    endtask

    task automatic do_stream(input int stop_after, input int next_base);
        int n, first, prev, bad_gap, s;
        bit done;
        logic [W-1:0] exp_w, last_w;
        n = 0; first = 0; prev = 0; bad_gap = 0; done = 1'b0; last_w = '0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (bus.dout_vld) begin
                if (n == 0) first = cyc;
                else if (cyc - prev != GAP + 1) bad_gap++;
                prev = cyc;
                n++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra pixel=%0d got=%h required=none", n - 1, bus.dout);
                end else begin
                    exp_w = sb_q.pop_front();
                    last_w = exp_w;
                    if (bus.dout !== exp_w) begin
                        errors++;
                        $display("FAIL stream_data pixel=%0d got=%h required=%h", n - 1, bus.dout, exp_w);
                    end
                end
                checks++;
                if (bus.dout_end !== (n == DEPTH)) begin
                    errors++;
                    $display("FAIL stream_end pixel=%0d got=%b required=%b", n - 1, bus.dout_end, n == DEPTH);
                end
                if (bus.dout_end || n == stop_after) done = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL stream_timeout got=%0d pixels required=%0d", n, stop_after);
        end
        if (stop_after < DEPTH) return;
        checks++;
        if (first - s != 2) begin
            errors++;
            $display("FAIL stream_latency got=%0d required=2", first - s);
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL stream_count got=%0d required=%0d", n, DEPTH);
        end
        checks++;
        if (bad_gap != 0 || (prev - first) != (DEPTH - 1) * (GAP + 1)) begin
            errors++;
            $display("FAIL stream_spacing got=%0d cycles (%0d bad gaps) required=%0d",
                     prev - first + 1, bad_gap, (DEPTH - 1) * (GAP + 1) + 1);
        end
        @(posedge clk); #1;
        if (next_base >= 0) begin
            bus.wr_vld = 1'b1;
            bus.wr_din = mk_word(next_base);
            bus.wr_end = 1'b0;
            sb_q.push_back(mk_word(next_base));
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.dout_vld !== 1'b0 || bus.dout !== last_w) begin
            errors++;
            $display("FAIL after_stream got busy=%b ready=%b vld=%b dout=%h required 0 0 0 %h",
                     bus.busy, bus.ready, bus.dout_vld, bus.dout, last_w);
        end
    endtask

    task automatic check_err(input string name, input logic required);
        checks++;
        if (bus.err !== required) begin
            errors++;
            $display("FAIL %s got err=%b required=%b", name, bus.err, required);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.ready, bus.busy, bus.dout_vld, bus.dout_end, bus.err} !== 5'b0 || bus.dout !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b busy=%b vld=%b end=%b err=%b dout=%h required all zero",
                     bus.ready, bus.busy, bus.dout_vld, bus.dout_end, bus.err, bus.dout);
        end
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL start_when_empty got busy=%b vld=%b required 0 0", bus.busy, bus.dout_vld);
        end
        check_err("start_when_empty_err", 1'b0);
    endtask

    task automatic test_fill_stream();
        ch_step = 0;
        write_frame(0, 0, DEPTH - 1, 1'b0, 1'b0);
        check_err("fill_err", 1'b0);
        do_stream(DEPTH, -1);
        check_err("stream_err", 1'b0);
        ch_step = 16'h100;
    endtask

    task automatic test_gappy_input();
        write_frame(100, 0, DEPTH - 1, 1'b1, 1'b0);
        do_stream(DEPTH, -1);
        check_err("gappy_err", 1'b0);
    endtask

    task automatic test_err_early_end();
        do_reset();
        write_frame(200, 0, 10, 1'b0, 1'b0);
        check_err("early_end_err", 1'b1);
        do_stream(DEPTH, -1);
        do_reset();
        write_frame(250, 0, -1, 1'b0, 1'b0);
        check_err("missing_end_err", 1'b1);
        do_stream(DEPTH, -1);
    endtask

    task automatic test_err_full_write();
        do_reset();
        write_frame(300, 0, DEPTH - 1, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.wr_vld = 1'b1; bus.wr_din = mk_word(999);
        @(posedge clk); #1;
        bus.wr_vld = 1'b0;
        @(negedge clk);
        check_err("full_write_err", 1'b1);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL full_write_ready got=%b required=1", bus.ready);
        end
        do_stream(DEPTH, -1);
    endtask

    task automatic test_start_on_last();
        do_reset();
        write_frame(400, 0, DEPTH - 1, 1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_on_last_ignored got busy=%b required=0", bus.busy);
        end
        do_stream(DEPTH, -1);
    endtask

    task automatic test_reset_mid_stream();
        write_frame(500, 0, DEPTH - 1, 1'b0, 1'b0);
        do_stream(21, -1);
        do_reset();
        checks++;
        if ({bus.dout_vld, bus.busy, bus.ready, bus.err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_stream got vld=%b busy=%b ready=%b err=%b required all zero",
                     bus.dout_vld, bus.busy, bus.ready, bus.err);
        end
        sb_q.delete();
        write_frame(600, 0, DEPTH - 1, 1'b0, 1'b0);
        do_stream(DEPTH, -1);
        check_err("after_reset_err", 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_frame(700, 0, DEPTH - 1, 1'b0, 1'b0);
        do_stream(DEPTH, 800);
        write_frame(800, 1, DEPTH - 1, 1'b0, 1'b0);
        do_stream(DEPTH, -1);
        check_err("back_to_back_err", 1'b0);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; ch_step = 16'h100;
        rst_n = 1'b0;
        bus.wr_vld = 1'b0; bus.wr_din = '0; bus.wr_end = 1'b0; bus.start = 1'b0;
        test_reset();
        test_fill_stream();
        test_gappy_input();
        test_err_early_end();
        test_err_full_write();
        test_start_on_last();
        test_reset_mid_stream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fmap_streamer.md
Name: fmap_streamer

Overview:
- Frame buffer and stream transmitter. It sits on the producer side of the per-pixel valid stream that the padding/dconv/pconv layer chain consumes.
- Captures one complete SIZE x SIZE feature map from an upstream layer output: all channels in parallel, one pixel per write.
- On a start request it replays that map in raster order as a vld/data/end stream, optionally throttled, to feed the next layer's input_vld/input_din.

Parameters:
N, 16, bit width of one channel sample
CHANNEL, 3, number of channels packed per pixel word
SIZE, 6, feature map height = width; frame holds SIZE*SIZE pixels
GAP, 0, idle cycles inserted between emitted pixels (used only when STREAM_GAP_EN is defined)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
wr_vld  input  1  upstream pixel valid (driven by a layer's conv_dout_vld)
wr_din  input  CHANNEL*N  upstream pixel; channel c occupies bits [c*N +: N]
wr_end  input  1  upstream last-pixel marker (a layer's conv_dout_end)
start  input  1  request to replay the stored frame
ready  output  1  a complete frame is stored and no replay is in progress
busy  output  1  replay in progress
dout_vld  output  1  output pixel valid (drives the next layer's input_vld)
dout  output  CHANNEL*N  output pixel
dout_end  output  1  high together with dout_vld on the last pixel
err  output  1  sticky protocol error flag

Behaviour:
- Storage: SIZE*SIZE words of CHANNEL*N bits. Write address wa and read address ra, each $clog2(SIZE*SIZE) bits wide. The memory read is registered.
- Reset (rst_n low at a clock edge): state=IDLE, wa=0, ra=0, ready=0, busy=0, dout_vld=0, dout=0, dout_end=0, err=0, gap counter=0.
- Reset mid-fill or mid-stream aborts immediately. The stored frame is discarded logically: ready=0. Memory contents are don't-care.
- FSM states:
  - IDLE: wr_vld writes mem[0], sets wa=1, goes to FILL. start while not ready is ignored and sets no error.
  - FILL: each wr_vld writes mem[wa], wa++. On the write with wa==SIZE*SIZE-1: wa=0, go to FULL, ready=1 the next cycle.
  - FILL, end checks: wr_end on any other write sets err; the frame still continues counting. If wr_end is missing on the final write, err is set; state still goes to FULL.
  - FULL: ready=1. wr_vld here overwrites nothing and sets err. start moves to STREAM with ready=0, busy=1, ra=0.
  - STREAM: each emit slot reads mem[ra], ra++. Emission is registered: start sampled at cycle t gives dout_vld=1 with mem[0] at t+2, one pixel per cycle thereafter (GAP=0).
  - STREAM, last pixel: dout_end=1 with it. The cycle after, busy=0, state=IDLE, ready=0.
  - STREAM, writes: wr_vld during STREAM is dropped and sets err.
- Frame lifetime: a frame is consumed once. To replay it again it must be refilled.
- Outputs between pixels: dout_vld and dout_end are single-cycle per pixel and low otherwise. dout holds its last value when dout_vld=0.
- Simultaneous events:
  - start in the same cycle as the final FILL write is ignored; start must arrive while ready=1.
  - wr_vld in the cycle the FSM returns to IDLE from STREAM is accepted as pixel 0 of a new frame.
- Total stream length: exactly SIZE*SIZE dout_vld pulses per start. The stream is never interrupted by input activity.
- err: cleared only by reset.

Optional Feature:
- Macro: STREAM_GAP_EN.
- Defined: after each emitted pixel except the last, the streamer holds dout_vld=0 for exactly GAP cycles before the next pixel. Stream duration is SIZE*SIZE + (SIZE*SIZE-1)*GAP cycles. GAP=0 behaves identically to the undefined build.
- Undefined: GAP is ignored and pixels are emitted back-to-back. No gap counter logic is synthesized.

Test Plan:
- Fill then stream, GAP=0: write pixels with value index k (all channels = k) for k=0..35 with wr_end on k=35, then pulse start. Required: ready=1 after fill; 36 consecutive dout_vld with dout channel values 0..35 starting 2 cycles after start; dout_end only on value 35; err=0; busy falls the cycle after.
- Gappy input: same frame with random 0-3 idle cycles between wr_vld. Required: identical output stream; ready asserts only after the 36th write.
- Protocol errors:
  - wr_end on pixel 10: err=1 and the frame still completes at 36 writes.
  - Separately, wr_vld while in FULL: err=1, and the subsequent stream still outputs the original 0..35.
- Reset mid-operation: assert rst_n=0 at stream pixel 20, then release. Required: dout_vld=0, busy=0, ready=0, err=0 next cycle; a new fill of 36 pixels streams correctly.
- STREAM_GAP_EN with GAP=2: stream a 36-pixel frame. Required: dout_vld high on every third cycle; total duration 106 cycles from first to last pixel; dout_end on the last pixel.
- Back-to-back: the first wr_vld of frame 2 lands in the cycle after frame 1's dout_end. Required: it is accepted as pixel 0 of frame 2, and frame 2 replays intact.
